// File: rtl/spi_master_core.sv
// rtl/spi_master_core.sv - Wishbone-controlled SPI master with programmable divider, length, edges and bit order
module spi_master_core #(
    parameter int SS_NB = 8,
    parameter int DIV_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic [4:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic             wb_int_o,
    output logic [SS_NB-1:0] ss_pad_o,
    output logic             sclk_pad_o,
    output logic             mosi_pad_o,
    input  logic             miso_pad_i
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [2:0] OFF_TX   = 3'd0;
    localparam logic [2:0] OFF_RX   = 3'd1;
    localparam logic [2:0] OFF_CTRL = 3'd2;
    localparam logic [2:0] OFF_DIV  = 3'd3;
    localparam logic [2:0] OFF_SS   = 3'd4;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_tx, r_rx, r_shift, r_dat;
    logic [13:0]      r_ctrl;
    logic [DIV_W-1:0] r_divider, r_div_cnt;
    logic [SS_NB-1:0] r_ss;
    logic             r_ack, r_int, r_sclk, r_mosi;
    logic [5:0]       r_len, r_tx_k, r_rx_k;
    logic [6:0]       r_edge_cnt;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] wr_v,
                                            input logic [3:0] sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = sel[i] ? wr_v[8*i +: 8] : old_v[8*i +: 8];
        return res;
    endfunction

    // Maps the k-th transmitted bit to its position inside the character
    function automatic logic [4:0] f_pos(input logic [5:0] k, input logic [5:0] len, input logic lsb);
        logic [5:0] p;
        p = lsb ? k : (len - 6'd1 - k);
        return p[4:0];
    endfunction

    logic             w_access, w_wr_ok, w_start, w_tick, w_rx_edge, w_tx_edge, w_last, w_unused;
    logic [2:0]       w_off;
    logic [31:0]      w_tx_wr, w_ctrl_wr, w_div_wr, w_ss_wr, w_rd_data, w_rx_mask;
    logic [13:0]      w_ctrl_new;
    logic [5:0]       w_len_new;
    logic [4:0]       w_tx_pos, w_rx_pos, w_first_pos;

    assign w_unused  = &{1'b0, wb_adr_i[1:0]};
    assign w_off     = wb_adr_i[4:2];
    assign w_access  = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr_ok   = w_access & wb_we_i & ~r_ctrl[8];

    assign w_tx_wr   = f_merge(r_tx, wb_dat_i, wb_sel_i);
    assign w_ctrl_wr = f_merge({18'b0, r_ctrl}, wb_dat_i, wb_sel_i);
    assign w_div_wr  = f_merge(32'(r_divider), wb_dat_i, wb_sel_i);
    assign w_ss_wr   = f_merge(32'(r_ss), wb_dat_i, wb_sel_i);
    assign w_ctrl_new = w_ctrl_wr[13:0] & 14'h3F3F;

    // Lengths beyond 32 have no meaning for a 32-bit shifter and are treated like 0
    assign w_len_new = (w_ctrl_new[5:0] == 6'd0 || w_ctrl_new[5:0] > 6'd32) ? 6'd32 : w_ctrl_new[5:0];
    assign w_start   = w_wr_ok && (w_off == OFF_CTRL) && w_ctrl_new[8] && (r_state == S_IDLE);

    assign w_tick    = (r_state == S_SHIFT) && (r_div_cnt == '0);
    assign w_rx_edge = w_tick && (r_ctrl[9]  ? r_sclk : ~r_sclk);
    assign w_tx_edge = w_tick && (r_ctrl[10] ? r_sclk : ~r_sclk);
    assign w_last    = w_tick && (r_edge_cnt == 7'd1);

    assign w_tx_pos    = f_pos(r_tx_k + 6'd1, r_len, r_ctrl[11]);
    assign w_rx_pos    = f_pos(r_rx_k, r_len, r_ctrl[11]);
    assign w_first_pos = f_pos(6'd0, w_len_new, w_ctrl_new[11]);
    assign w_rx_mask   = 32'hFFFF_FFFF >> (6'd32 - r_len);

    always_comb begin
        w_rd_data = 32'h0;
        case (w_off)
            OFF_TX:   w_rd_data = r_tx;
            OFF_RX:   w_rd_data = r_rx;
            OFF_CTRL: w_rd_data = {18'b0, r_ctrl};
            OFF_DIV:  w_rd_data = 32'(r_divider);
            OFF_SS:   w_rd_data = 32'(r_ss);
            default:  w_rd_data = 32'h0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_shift    <= 32'h0;
            r_len      <= 6'd0;
            r_tx_k     <= 6'd0;
            r_rx_k     <= 6'd0;
            r_edge_cnt <= 7'd0;
            r_div_cnt  <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
        end else if (w_start) begin
            r_shift    <= r_tx;
            r_len      <= w_len_new;
            r_tx_k     <= 6'd0;
            r_rx_k     <= 6'd0;
            r_edge_cnt <= {w_len_new, 1'b0};
            r_div_cnt  <= r_divider;
            r_sclk     <= 1'b0;
            r_mosi     <= r_tx[w_first_pos];
        end else if (r_state == S_SHIFT) begin
            if (r_div_cnt != '0) begin
                r_div_cnt <= r_div_cnt - DIV_W'(1);
            end else begin
                r_div_cnt  <= r_divider;
                r_sclk     <= ~r_sclk;
                r_edge_cnt <= r_edge_cnt - 7'd1;
                if (w_rx_edge) begin
                    r_shift[w_rx_pos] <= miso_pad_i;
                    r_rx_k            <= r_rx_k + 6'd1;
                end
                // Bits still to send are read before they can be overwritten by received ones
                if (w_tx_edge && !w_last && ((r_tx_k + 6'd1) < r_len)) begin
                    r_mosi <= r_shift[w_tx_pos];
                    r_tx_k <= r_tx_k + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_ack     <= 1'b0;
            r_dat     <= 32'h0;
            r_tx      <= 32'h0;
            r_rx      <= 32'h0;
            r_ctrl    <= 14'h0;
            r_divider <= '0;
            r_ss      <= '0;
            r_int     <= 1'b0;
        end else begin
            r_ack <= wb_cyc_i & wb_stb_i & ~r_ack;
            r_dat <= w_access ? w_rd_data : 32'h0;
            if (w_wr_ok) begin
                case (w_off)
                    OFF_TX:   r_tx      <= w_tx_wr;
                    OFF_CTRL: r_ctrl    <= w_ctrl_new;
                    OFF_DIV:  r_divider <= w_div_wr[DIV_W-1:0];
                    OFF_SS:   r_ss      <= w_ss_wr[SS_NB-1:0];
                    default:  ;
                endcase
            end
            if (r_state == S_DONE) begin
                r_rx      <= r_shift & w_rx_mask;
                r_ctrl[8] <= 1'b0;
                r_int     <= r_ctrl[12];
            end else if (w_access) begin
                r_int <= 1'b0;
            end
        end
    end

    assign wb_ack_o   = r_ack;
    assign wb_dat_o   = r_dat;
    assign wb_err_o   = 1'b0;
    assign wb_int_o   = r_int;
    assign sclk_pad_o = r_sclk;
    assign mosi_pad_o = r_mosi;
    assign ss_pad_o   = (r_ctrl[13] && r_state != S_SHIFT) ? {SS_NB{1'b1}} : ~r_ss;
endmodule

// File: tb/tb_spi_master_core.sv
// tb/tb_spi_master_core.sv - scoreboard bench for spi_master_core
module tb_spi_master_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  adr = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, stb = 1'b0, cyc = 1'b0;
    logic        ack, err, intr;
    logic [7:0]  ss;
    logic        sclk, mosi, miso;

    logic        loopback = 1'b1;
    logic [31:0] slave_tx = '0, slave_rx = '0;

    int n_vec = 0;
    int n_err = 0;
    logic exp_q[$];
    logic obs_q[$];

    spi_master_core #(.SS_NB(8), .DIV_W(16)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
        .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack),
        .wb_err_o(err), .wb_int_o(intr), .ss_pad_o(ss), .sclk_pad_o(sclk),
        .mosi_pad_o(mosi), .miso_pad_i(miso)
    );

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : slave_tx[31];
    always @(posedge sclk) slave_rx = {slave_rx[30:0], mosi};
    always @(negedge sclk) slave_tx = slave_tx << 1;

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    task automatic wb_cycle(input logic w, input logic [4:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd, output int lat,
                            output logic int_at_ack);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack && lat < 20);
        rd = dat_o;
        int_at_ack = intr;
        if (!ack) begin
            n_vec++; n_err++;
            $display("FAIL bus_timeout adr=%h ack=%b required 1", a, ack);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] rd; int lat; logic ia;
        wb_cycle(1'b1, a, d, 4'hF, rd, lat, ia);
    endtask

    task automatic wb_read(input logic [4:0] a, output logic [31:0] d);
        int lat; logic ia;
        wb_cycle(1'b0, a, 32'h0, 4'hF, d, lat, ia);
    endtask

    // Records mosi at each sclk rise into obs_q until sclk has been quiet for a while
    task automatic wait_transfer(input int div, output int rises, output int period, output logic ss_ok);
        int quiet, first, c;
        logic prev;
        rises = 0; period = -1; ss_ok = 1'b1; quiet = 0; first = 0; prev = sclk;
        obs_q.delete();
        for (c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (sclk && !prev) begin
                obs_q.push_back(mosi);
                rises++;
                if (rises == 1) first = c;
                if (rises == 2) period = c - first;
            end
            if (sclk && ss[0] !== 1'b0) ss_ok = 1'b0;
            prev = sclk;
            if (rises > 0 && !sclk) quiet++; else quiet = 0;
            if (quiet > 2 * (div + 1) + 4) break;
        end
        if (c >= 3000) begin
            n_vec++; n_err++;
            $display("FAIL transfer_timeout rises=%0d", rises);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        n_vec++; if (sclk !== 1'b0) begin n_err++; $display("FAIL rst_sclk got %b want 0", sclk); end
        n_vec++; if (ss !== 8'hFF) begin n_err++; $display("FAIL rst_ss got %h want ff", ss); end
        n_vec++; if (mosi !== 1'b0) begin n_err++; $display("FAIL rst_mosi got %b want 0", mosi); end
        n_vec++; if ({ack, intr, err} !== 3'b000) begin n_err++; $display("FAIL rst_ack_int got %b want 000", {ack, intr, err}); end
        n_vec++; if (dat_o !== 32'h0) begin n_err++; $display("FAIL rst_dat got %h want 0", dat_o); end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wb_read(5'(i * 4), d);
            n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_reg%0d got %h want 0", i, d); end
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd, d; int lat; logic ia;
        wb_write(5'h00, 32'h0);
        wb_cycle(1'b1, 5'h00, 32'h1122_3344, 4'b0101, rd, lat, ia);
        wb_read(5'h00, d);
        n_vec++; if (d !== 32'h0022_0044) begin n_err++; $display("FAIL byte_lanes got %h want 00220044", d); end
    endtask

    task automatic test_mode0_loopback();
        logic [31:0] d, v; int rises, period; logic ss_ok, o, e;
        loopback = 1'b1;
        wb_write(5'h0C, 32'd1);
        wb_write(5'h00, 32'hA5);
        wb_write(5'h10, 32'h1);
        v = 32'hA5;
        for (int i = 7; i >= 0; i--) exp_q.push_back(v[i]);
        wb_write(5'h08, 32'h3508);
        wait_transfer(1, rises, period, ss_ok);
        n_vec++; if (rises !== 8) begin n_err++; $display("FAIL m0_rises got %0d want 8", rises); end
        n_vec++; if (period !== 4) begin n_err++; $display("FAIL m0_period got %0d want 4", period); end
        n_vec++; if (!ss_ok) begin n_err++; $display("FAIL m0_ss_active got high want low during shift"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
            n_vec++; if (o !== e) begin n_err++; $display("FAIL m0_mosi got %b want %b", o, e); end
        end
        n_vec++; if (ss !== 8'hFF) begin n_err++; $display("FAIL m0_ss_idle got %h want ff", ss); end
        n_vec++; if (intr !== 1'b1) begin n_err++; $display("FAIL m0_int got %b want 1", intr); end
        wb_read(5'h04, d);
        n_vec++; if (d !== 32'hA5) begin n_err++; $display("FAIL m0_rx got %h want a5", d); end
        wb_read(5'h08, d);
        n_vec++; if (d !== 32'h3408) begin n_err++; $display("FAIL m0_ctrl_go got %h want 3408", d); end
    endtask

    task automatic test_lsb32_slave();
        logic [31:0] d, v; int rises, period; logic ss_ok, o, e;
        loopback = 1'b0;
        slave_tx = 32'hC3A5_0F96;
        slave_rx = 32'h0;
        wb_write(5'h0C, 32'd0);
        wb_write(5'h00, 32'h8000_0001);
        v = 32'h8000_0001;
        for (int i = 0; i < 32; i++) exp_q.push_back(v[i]);
        wb_write(5'h08, 32'h2D00);
        wait_transfer(0, rises, period, ss_ok);
        n_vec++; if (rises !== 32) begin n_err++; $display("FAIL l32_rises got %0d want 32", rises); end
        n_vec++; if (period !== 2) begin n_err++; $display("FAIL l32_period got %0d want 2", period); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
            n_vec++; if (o !== e) begin n_err++; $display("FAIL l32_mosi got %b want %b", o, e); end
        end
        wb_read(5'h04, d);
        n_vec++; if (d !== bitrev(32'hC3A5_0F96)) begin n_err++; $display("FAIL l32_rx got %h want %h", d, bitrev(32'hC3A5_0F96)); end
        n_vec++; if (slave_rx !== bitrev(32'h8000_0001)) begin n_err++; $display("FAIL l32_slave_rx got %h want %h", slave_rx, bitrev(32'h8000_0001)); end
        n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL l32_int got %b want 0", intr); end
        loopback = 1'b1;
    endtask

    task automatic test_busy_lock();
        logic [31:0] d, v; int rises, period; logic ss_ok, o, e;
        loopback = 1'b1;
        wb_write(5'h0C, 32'd3);
        wb_write(5'h00, 32'h3C);
        v = 32'h3C;
        for (int i = 7; i >= 0; i--) exp_q.push_back(v[i]);
        wb_write(5'h08, 32'h0508);
        fork
            begin
                wb_write(5'h00, 32'hFFFF_FFFF);
                wb_write(5'h0C, 32'd5);
            end
            wait_transfer(3, rises, period, ss_ok);
        join
        n_vec++; if (rises !== 8) begin n_err++; $display("FAIL busy_rises got %0d want 8", rises); end
        n_vec++; if (period !== 8) begin n_err++; $display("FAIL busy_period got %0d want 8", period); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
            n_vec++; if (o !== e) begin n_err++; $display("FAIL busy_mosi got %b want %b", o, e); end
        end
        wb_read(5'h00, d);
        n_vec++; if (d !== 32'h3C) begin n_err++; $display("FAIL busy_tx got %h want 3c", d); end
        wb_read(5'h0C, d);
        n_vec++; if (d !== 32'd3) begin n_err++; $display("FAIL busy_div got %h want 3", d); end
        wb_read(5'h04, d);
        n_vec++; if (d !== 32'h3C) begin n_err++; $display("FAIL busy_rx got %h want 3c", d); end
    endtask

    task automatic test_int_clear();
        logic [31:0] d; int rises, period, lat; logic ss_ok, ia;
        wb_write(5'h0C, 32'd0);
        wb_write(5'h00, 32'h5A);
        wb_write(5'h08, 32'h1508);
        wait_transfer(0, rises, period, ss_ok);
        n_vec++; if (intr !== 1'b1) begin n_err++; $display("FAIL int_set got %b want 1", intr); end
        wb_cycle(1'b0, 5'h04, 32'h0, 4'hF, d, lat, ia);
        n_vec++; if (d !== 32'h5A) begin n_err++; $display("FAIL int_rx got %h want 5a", d); end
        n_vec++; if (ia !== 1'b0) begin n_err++; $display("FAIL int_clear_at_ack got %b want 0", ia); end
        wb_write(5'h00, 32'h77);
        wb_write(5'h08, 32'h0508);
        wait_transfer(0, rises, period, ss_ok);
        n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL int_ie0 got %b want 0", intr); end
        wb_read(5'h04, d);
        n_vec++; if (d !== 32'h77) begin n_err++; $display("FAIL int_ie0_rx got %h want 77", d); end
        obs_q.delete();
    endtask

    task automatic test_unmapped();
        logic [31:0] d; int lat; logic ia;
        wb_write(5'h1C, 32'hFFFF_FFFF);
        wb_cycle(1'b0, 5'h1C, 32'h0, 4'hF, d, lat, ia);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_data got %h want 0", d); end
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL unmapped_latency got %0d want 1", lat); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL unmapped_err got %b want 0", err); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wb_write(5'h0C, 32'd3);
        wb_write(5'h10, 32'h0F);
        wb_write(5'h00, 32'hFFFF);
        wb_write(5'h08, 32'h1510);
        repeat (30) @(negedge clk);
        n_vec++; if (ss !== 8'hF0) begin n_err++; $display("FAIL mid_ss_pre got %h want f0", ss); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (sclk !== 1'b0) begin n_err++; $display("FAIL mid_sclk got %b want 0", sclk); end
        n_vec++; if (ss !== 8'hFF) begin n_err++; $display("FAIL mid_ss got %h want ff", ss); end
        n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL mid_int got %b want 0", intr); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL mid_int_after got %b want 0", intr); end
        for (int i = 0; i < 5; i++) begin
            wb_read(5'(i * 4), d);
            n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_reg%0d got %h want 0", i, d); end
        end
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_mode0_loopback();
        test_lsb32_slave();
        test_busy_lock();
        test_int_clear();
        test_unmapped();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
